stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_stack_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// stack_ctrl: stack engine executing PUSH/POP/CALL/RET against memory and the register file.
// Latency: PUSH/CALL/RET and POP-to-SP complete 3 cycles after start, POP to A/X/Y 4, errors 1; memory wait states add on top.
// Backpressure: mem_we/mem_re held until mem_ready; start is ignored (not queued) while busy.
// Optional feature: define STACK_BOUNDS_CHECK_EN to reject PUSH/CALL at STACK_LIMIT and POP/RET at STACK_BASE.
module stack_ctrl #(
  parameter logic [15:0] STACK_BASE  = 16'hFF00,
  parameter logic [15:0] STACK_LIMIT = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] push_data,
  input  logic [2:0]  dst_sel,
  input  logic [15:0] pc_in,
  input  logic [15:0] call_target,
  input  logic [15:0] sp_in,
  output logic [2:0]  rf_reg_sel,
  output logic [15:0] rf_wdata,
  output logic        rf_write_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] pc_out,
  output logic        pc_load,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;
  localparam logic [2:0] REG_SP  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_WB_SP,
    S_WB_REG,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  op_q;
  logic [2:0]  dst_q;
  logic [15:0] wdata_q;
  logic [15:0] target_q;
  logic [15:0] sp_q;
  logic [15:0] data_q;
  logic        err_q;

  logic        bounds_err;
  logic        cmd_err;
  logic        is_write;
  logic        pop_to_sp;
  logic        pop_to_reg;

`ifdef STACK_BOUNDS_CHECK_EN
  // A full stack cannot take another word; an empty stack has nothing to pop.
  assign bounds_err = ((op == OP_PUSH || op == OP_CALL) && (sp_in == STACK_LIMIT)) ||
                      ((op == OP_POP  || op == OP_RET)  && (sp_in == STACK_BASE));
`else
  // No bounds checking: SP wraps freely. The expression is constant zero but keeps
  // the bound parameters referenced in this build.
  assign bounds_err = (STACK_BASE == STACK_LIMIT) && 1'b0;
`endif

  // Only a POP names a destination, and only A/X/Y/SP (0xx) are legal.
  assign cmd_err    = bounds_err || ((op == OP_POP) && dst_sel[2]);

  // PUSH and CALL both write memory at SP-1; POP and RET both read memory at SP.
  assign is_write   = (op_q == OP_PUSH) || (op_q == OP_CALL);
  assign pop_to_sp  = (op_q == OP_POP) && (dst_q == REG_SP);
  assign pop_to_reg = (op_q == OP_POP) && (dst_q != REG_SP);

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command capture on an accepted start, read-data capture when memory completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      dst_q    <= '0;
      wdata_q  <= '0;
      target_q <= '0;
      sp_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        op_q     <= op;
        dst_q    <= dst_sel;
        wdata_q  <= (op == OP_CALL) ? pc_in : push_data;
        target_q <= call_target;
        sp_q     <= sp_in;
        err_q    <= cmd_err;
      end
      if (state == S_MEM && !is_write && mem_ready) begin
        data_q <= mem_rdata;
      end
    end
  end

  // Next-state and Moore outputs; everything is low unless the state asserts it.
  always_comb begin
    state_nxt   = state;
    rf_reg_sel  = '0;
    rf_wdata    = '0;
    rf_write_en = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    pc_out      = '0;
    pc_load     = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = cmd_err ? S_DONE : S_MEM;
        end
      end
      S_MEM: begin
        if (is_write) begin
          mem_we    = 1'b1;
          mem_addr  = sp_q - 16'd1;
          mem_wdata = wdata_q;
          if (mem_ready) begin
            state_nxt = S_WB_SP;
          end
        end else begin
          mem_re   = 1'b1;
          mem_addr = sp_q;
          if (mem_ready) begin
            state_nxt = pop_to_reg ? S_WB_REG : S_WB_SP;
          end
        end
      end
      S_WB_REG: begin
        rf_write_en = 1'b1;
        rf_reg_sel  = dst_q;
        rf_wdata    = data_q;
        state_nxt   = S_WB_SP;
      end
      S_WB_SP: begin
        rf_write_en = 1'b1;
        rf_reg_sel  = REG_SP;
        if (is_write) begin
          rf_wdata = sp_q - 16'd1;
        end else if (pop_to_sp) begin
          // Popped value becomes SP directly; no post-increment.
          rf_wdata = data_q;
        end else begin
          rf_wdata = sp_q + 16'd1;
        end
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
        if (!err_q && op_q == OP_CALL) begin
          pc_load = 1'b1;
          pc_out  = target_q;
        end else if (!err_q && op_q == OP_RET) begin
          pc_load = 1'b1;
          pc_out  = data_q;
        end
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed bench for stack_ctrl with a transaction-level stack/memory model.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// Memory responder inserts a programmable number of wait states per request.
module tb_stack_ctrl;

  localparam logic [1:0]  PUSH  = 2'b00;
  localparam logic [1:0]  POP   = 2'b01;
  localparam logic [1:0]  CALL  = 2'b10;
  localparam logic [1:0]  RET   = 2'b11;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam logic [15:0] LIMIT = 16'hFE00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] push_data = '0;
  logic [2:0]  dst_sel = '0;
  logic [15:0] pc_in = '0;
  logic [15:0] call_target = '0;
  logic [15:0] sp_in = '0;
  logic [2:0]  rf_reg_sel;
  logic [15:0] rf_wdata;
  logic        rf_write_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] pc_out;
  logic        pc_load;
  logic        busy;
  logic        done;
  logic        err;

  stack_ctrl #(.STACK_BASE(BASE), .STACK_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .push_data(push_data),
    .dst_sel(dst_sel), .pc_in(pc_in), .call_target(call_target), .sp_in(sp_in),
    .rf_reg_sel(rf_reg_sel), .rf_wdata(rf_wdata), .rf_write_en(rf_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_out(pc_out), .pc_load(pc_load),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model memory and SP; the responder answers from the same memory image.
  logic [15:0] mem_m [0:65535];
  logic [15:0] m_sp = BASE;
  int          stall_req = 0;
  int          req_age = 0;
  assign mem_ready = (mem_we || mem_re) && (req_age > stall_req);
  assign mem_rdata = mem_re ? mem_m[mem_addr] : 16'h0000;

  // Expected transaction of the command in flight.
  bit          active = 1'b0;
  int          cyc = 0;
  int          exp_lat = 0;
  logic [1:0]  exp_req = 2'b00;
  logic [15:0] exp_addr = '0;
  logic [15:0] exp_wdata = '0;
  logic        exp_pcl = 1'b0;
  logic [15:0] exp_pc = '0;
  logic        exp_err = 1'b0;
  logic [18:0] exp_q [$];
  bit          mem_seen = 1'b0;

  // Restore point for an aborted command.
  logic [15:0] save_sp = '0;
  logic [15:0] save_addr = '0;
  logic [15:0] save_word = '0;

  // Last observed DUT activity, pinned against literals.
  logic [15:0] cap_addr = '0, cap_wdata = '0, cap_sp_w = '0, cap_reg_w = '0, cap_pc = '0;
  logic [2:0]  cap_reg_sel = '0;
  logic        cap_err = 1'b0, cap_pcl = 1'b0;
  int          cap_lat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Per-cycle comparison of every DUT output against the expected transaction.
  task automatic monitor();
    logic [18:0] e;
    if (active) cyc++;
    check("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
    check("busy", 32'(busy), 32'(active));
    if (mem_we || mem_re) begin
      mem_seen = 1'b1;
      check("mem_req", 32'({mem_we, mem_re}), 32'(exp_req));
      check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (mem_we) check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      cap_addr  = mem_addr;
      cap_wdata = mem_wdata;
      req_age++;
    end else begin
      req_age = 0;
    end
    if (rf_write_en) begin
      if (exp_q.size() == 0) begin
        check("rf_write_unexpected", 32'(rf_write_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rf_reg_sel", 32'(rf_reg_sel), 32'(e[18:16]));
        check("rf_wdata", 32'(rf_wdata), 32'(e[15:0]));
        if (rf_reg_sel == 3'b011) cap_sp_w = rf_wdata;
        else begin
          cap_reg_w   = rf_wdata;
          cap_reg_sel = rf_reg_sel;
        end
      end
    end
    if (!done) begin
      if (pc_load) check("pc_load_without_done", 32'(pc_load), 32'd0);
      if (err) check("err_without_done", 32'(err), 32'd0);
    end else begin
      check("done_only_for_command", 32'(done), 32'(active));
      if (active) begin
        check("done_err", 32'(err), 32'(exp_err));
        check("done_pc_load", 32'(pc_load), 32'(exp_pcl));
        if (exp_pcl) check("done_pc_out", 32'(pc_out), 32'(exp_pc));
        check("latency", 32'(cyc), 32'(exp_lat));
        check("rf_writes_missing", 32'(exp_q.size()), 32'd0);
        check("mem_access", 32'(mem_seen), 32'(exp_req != 2'b00));
        cap_err = err;
        cap_pcl = pc_load;
        cap_pc  = pc_out;
        cap_lat = cyc;
        active  = 1'b0;
        exp_req = 2'b00;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  // Compute the command's outcome from the stack rules, then issue it.
  task automatic begin_cmd(input logic [1:0] c_op, input logic [15:0] c_pd, input logic [2:0] c_dst,
                           input logic [15:0] c_pc, input logic [15:0] c_tgt, input int c_stall);
    logic [15:0] sp;
    logic [15:0] val;
    logic        e_err;
    sp    = m_sp;
    e_err = (c_op == POP) && c_dst[2];
`ifdef STACK_BOUNDS_CHECK_EN
    if ((c_op == PUSH || c_op == CALL) && sp == LIMIT) e_err = 1'b1;
    if ((c_op == POP || c_op == RET) && sp == BASE) e_err = 1'b1;
`endif
    exp_q.delete();
    exp_err   = e_err;
    exp_pcl   = 1'b0;
    exp_pc    = '0;
    exp_req   = 2'b00;
    exp_addr  = '0;
    exp_wdata = '0;
    mem_seen  = 1'b0;
    save_sp   = sp;
    save_addr = sp - 16'd1;
    save_word = mem_m[save_addr];
    if (e_err) begin
      exp_lat = 1;
    end else begin
      case (c_op)
        PUSH, CALL: begin
          val       = (c_op == PUSH) ? c_pd : c_pc;
          exp_req   = 2'b10;
          exp_addr  = sp - 16'd1;
          exp_wdata = val;
          mem_m[exp_addr] = val;
          exp_q.push_back({3'b011, exp_addr});
          m_sp      = exp_addr;
          exp_pcl   = (c_op == CALL);
          exp_pc    = c_tgt;
          exp_lat   = 3 + c_stall;
        end
        POP: begin
          val      = mem_m[sp];
          exp_req  = 2'b01;
          exp_addr = sp;
          if (c_dst == 3'b011) begin
            exp_q.push_back({3'b011, val});
            m_sp    = val;
            exp_lat = 3 + c_stall;
          end else begin
            exp_q.push_back({c_dst, val});
            m_sp = sp + 16'd1;
            exp_q.push_back({3'b011, m_sp});
            exp_lat = 4 + c_stall;
          end
        end
        default: begin
          val      = mem_m[sp];
          exp_req  = 2'b01;
          exp_addr = sp;
          m_sp     = sp + 16'd1;
          exp_q.push_back({3'b011, m_sp});
          exp_pcl  = 1'b1;
          exp_pc   = val;
          exp_lat  = 3 + c_stall;
        end
      endcase
    end
    sp_in       = sp;
    op          = c_op;
    push_data   = c_pd;
    dst_sel     = c_dst;
    pc_in       = c_pc;
    call_target = c_tgt;
    stall_req   = c_stall;
    start       = 1'b1;
    active      = 1'b1;
    cyc         = 0;
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; optionally pulse start while busy or on the done cycle.
  task automatic wait_cmd(input bit poke, input bit start_at_done);
    for (int i = 0; i < 60 && active; i++) begin
      step();
      if (poke && active && cyc < stall_req) begin
        start   = ~start;
        op      = POP;
        dst_sel = 3'b000;
      end else begin
        start = 1'b0;
      end
    end
    if (active) begin
      check("cmd_timeout", 32'(cyc), 32'(exp_lat));
      active = 1'b0;
      exp_q.delete();
      exp_req = 2'b00;
    end
    if (start_at_done) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  task automatic run_cmd(input logic [1:0] c_op, input logic [15:0] c_pd, input logic [2:0] c_dst,
                         input logic [15:0] c_pc, input logic [15:0] c_tgt);
    begin_cmd(c_op, c_pd, c_dst, c_pc, c_tgt, 0);
    wait_cmd(1'b0, 1'b0);
    step();
  endtask

  initial begin
    logic [1:0] lop;
    for (int a = 0; a < 65536; a++) mem_m[a] = 16'(a) ^ 16'h5A5A;

    // Reset: every output idle.
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_we_re", 32'({mem_we, mem_re}), 32'd0);
    check("rst_rf_write_en", 32'(rf_write_en), 32'd0);
    check("rst_outputs_zero", 32'(rf_reg_sel | rf_wdata | mem_addr | mem_wdata | pc_out), 32'd0);
    rst = 1'b0;
    step();

    // PUSH 1234 at FF00.
    run_cmd(PUSH, 16'h1234, 3'b000, 16'h0, 16'h0);
    check("lit_push_addr", 32'(cap_addr), 32'h0000FEFF);
    check("lit_push_wdata", 32'(cap_wdata), 32'h00001234);
    check("lit_push_sp", 32'(cap_sp_w), 32'h0000FEFF);
    check("lit_push_lat", 32'(cap_lat), 32'd3);

    // POP into X.
    run_cmd(POP, 16'h0, 3'b001, 16'h0, 16'h0);
    check("lit_pop_sel", 32'(cap_reg_sel), 32'd1);
    check("lit_pop_x", 32'(cap_reg_w), 32'h00001234);
    check("lit_pop_sp", 32'(cap_sp_w), 32'h0000FF00);
    check("lit_pop_lat", 32'(cap_lat), 32'd4);
    check("lit_pop_err", 32'(cap_err), 32'd0);

    // CALL then RET.
    run_cmd(CALL, 16'h0, 3'b000, 16'h0042, 16'h0200);
    check("lit_call_wdata", 32'(cap_wdata), 32'h00000042);
    check("lit_call_sp", 32'(cap_sp_w), 32'h0000FEFF);
    check("lit_call_pc", 32'(cap_pc), 32'h00000200);
    run_cmd(RET, 16'h0, 3'b000, 16'h0, 16'h0);
    check("lit_ret_pc", 32'(cap_pc), 32'h00000042);
    check("lit_ret_sp", 32'(cap_sp_w), 32'h0000FF00);
    check("lit_ret_lat", 32'(cap_lat), 32'd3);

    // PUSH with 5 wait states and start pulses while busy.
    begin_cmd(PUSH, 16'hABCD, 3'b000, 16'h0, 16'h0, 5);
    wait_cmd(1'b1, 1'b0);
    step();
    check("lit_stall_lat", 32'(cap_lat), 32'd8);
    check("lit_stall_addr", 32'(cap_addr), 32'h0000FEFF);
    run_cmd(POP, 16'h0, 3'b010, 16'h0, 16'h0);
    check("lit_pop_y", 32'(cap_reg_w), 32'h0000ABCD);

    // POP into SP takes the popped value with no increment.
    run_cmd(PUSH, 16'h8000, 3'b000, 16'h0, 16'h0);
    run_cmd(POP, 16'h0, 3'b011, 16'h0, 16'h0);
    check("lit_pop_sp_val", 32'(cap_sp_w), 32'h00008000);
    check("lit_pop_sp_lat", 32'(cap_lat), 32'd3);

    // Illegal destination: immediate error, then start on the done cycle is dropped.
    run_cmd(POP, 16'h0, 3'b100, 16'h0, 16'h0);
    check("lit_bad_dst_err", 32'(cap_err), 32'd1);
    check("lit_bad_dst_lat", 32'(cap_lat), 32'd1);
    begin_cmd(POP, 16'h0, 3'b110, 16'h0, 16'h0, 0);
    wait_cmd(1'b0, 1'b1);
    step();

    // SP wraps modulo 2^16.
    m_sp = 16'h0000;
    run_cmd(PUSH, 16'h5555, 3'b000, 16'h0, 16'h0);
    check("lit_wrap_addr", 32'(cap_addr), 32'h0000FFFF);
    check("lit_wrap_sp", 32'(cap_sp_w), 32'h0000FFFF);
    run_cmd(POP, 16'h0, 3'b000, 16'h0, 16'h0);
    check("lit_wrap_back", 32'(cap_sp_w), 32'h00000000);

    // Stack bounds.
    m_sp = BASE;
    run_cmd(POP, 16'h0, 3'b000, 16'h0, 16'h0);
`ifdef STACK_BOUNDS_CHECK_EN
    check("lit_empty_pop_err", 32'(cap_err), 32'd1);
    check("lit_empty_pop_lat", 32'(cap_lat), 32'd1);
`else
    check("lit_empty_pop_data", 32'(cap_reg_w), 32'h0000A55A);
    check("lit_empty_pop_sp", 32'(cap_sp_w), 32'h0000FF01);
`endif
    m_sp = LIMIT;
    run_cmd(PUSH, 16'h1111, 3'b000, 16'h0, 16'h0);
`ifdef STACK_BOUNDS_CHECK_EN
    check("lit_full_push_err", 32'(cap_err), 32'd1);
`else
    check("lit_full_push_addr", 32'(cap_addr), 32'h0000FDFF);
`endif
    m_sp = LIMIT;
    run_cmd(CALL, 16'h0, 3'b000, 16'h0300, 16'h0400);
`ifdef STACK_BOUNDS_CHECK_EN
    check("lit_full_call_pcl", 32'(cap_pcl), 32'd0);
`else
    check("lit_full_call_pc", 32'(cap_pc), 32'h00000400);
`endif

    // Mixed sequence with varied wait states and done-cycle start pulses.
    m_sp = 16'hFF10;
    for (int i = 0; i < 8; i++) begin
      lop = 2'(i);
      begin_cmd(lop, 16'(i * 16'h1111), 3'(i % 3), 16'(16'h0100 + i), 16'(16'h0800 + i), i % 3);
      wait_cmd(1'b0, i[0]);
      step();
    end

    // Reset in the middle of a stalled PUSH: no writeback follows.
    begin_cmd(PUSH, 16'h7777, 3'b000, 16'h0, 16'h0, 10);
    step();
    check("abort_in_mem", 32'(mem_we), 32'd1);
    rst    = 1'b1;
    active = 1'b0;
    exp_q.delete();
    exp_req = 2'b00;
    m_sp    = save_sp;
    mem_m[save_addr] = save_word;
    step();
    rst       = 1'b0;
    stall_req = 0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_rf_write_en", 32'(rf_write_en), 32'd0);
    repeat (4) step();
    run_cmd(POP, 16'h0, 3'b001, 16'h0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
